// File: rtl/clkdiv_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clkdiv_ctrl_if                                               |
// | Description : Divisor configuration valid/ready port for clkdiv_ctrl.      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface clkdiv_ctrl_if #(
    parameter int W = 8
);
    logic         cfg_valid;
    logic [W-1:0] cfg_div;
    logic         cfg_ready;
    logic         cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/clkdiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clkdiv_ctrl                                                  |
// | Description : Glitch-free 50%-duty programmable clock divider controller.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module clkdiv_ctrl #(
    parameter int W           = 8,
    parameter int DEFAULT_DIV = 5
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         en,
    clkdiv_ctrl_if.slave      cfg,
    output logic              clk_out,
    output logic              running,
    output logic [W-1:0]      div_cur,
    output logic              period_tick
);

    localparam logic [W-1:0] c_div_rst = W'(DEFAULT_DIV);
    localparam logic [W-1:0] c_div_min = W'(2);
    localparam logic [W-1:0] c_one     = W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t       r_state,       w_state_nxt;
    logic [W-1:0] r_cnt,         w_cnt_nxt;
    logic [W-1:0] r_div_cur,     w_div_cur_nxt;
    logic [W-1:0] r_div_pend,    w_div_pend_nxt;
    logic         r_pending,     w_pending_nxt;
    logic         r_pos_hi,      w_pos_hi_nxt;
    logic         r_period_tick, w_tick_nxt;
    logic         r_cfg_err,     w_cfg_err_nxt;
    logic         r_neg_ext;

    logic         w_xfer;
    logic         w_cfg_ok;
    logic         w_wrap;

    assign w_xfer   = cfg.cfg_valid & ~r_pending;
    assign w_cfg_ok = (cfg.cfg_div >= c_div_min);
    assign w_wrap   = (r_state == S_RUN) && (r_cnt == (r_div_cur - c_one));

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_div_cur_nxt  = r_div_cur;
        w_div_pend_nxt = r_div_pend;
        w_pending_nxt  = r_pending;
        w_tick_nxt     = 1'b0;
        w_cfg_err_nxt  = w_xfer & ~w_cfg_ok;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                // A value captured on the final wrap before stopping is applied here.
                if (r_pending) begin
                    w_div_cur_nxt = r_div_pend;
                    w_pending_nxt = 1'b0;
                end
                if (w_xfer && w_cfg_ok) begin
                    w_div_cur_nxt = cfg.cfg_div;
                end
                if (en) begin
                    w_state_nxt = S_RUN;
                    w_tick_nxt  = 1'b1;
                end
            end
            S_RUN: begin
                w_cnt_nxt = r_cnt + c_one;
                if (w_wrap) begin
                    w_cnt_nxt = '0;
                    if (r_pending) begin
                        w_div_cur_nxt = r_div_pend;
                        w_pending_nxt = 1'b0;
                    end
                    if (!en) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_tick_nxt = 1'b1;
                    end
                end
                // Only reachable when nothing is pending, so it never races the clear above.
                if (w_xfer && w_cfg_ok) begin
                    w_div_pend_nxt = cfg.cfg_div;
                    w_pending_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // High phase covers cnt in [0, floor(N/2)-1] of the divisor that governs the next cycle.
        w_pos_hi_nxt = (w_state_nxt == S_RUN) && (w_cnt_nxt < (w_div_cur_nxt >> 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_div_cur     <= c_div_rst;
            r_div_pend    <= '0;
            r_pending     <= 1'b0;
            r_pos_hi      <= 1'b0;
            r_period_tick <= 1'b0;
            r_cfg_err     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_div_cur     <= w_div_cur_nxt;
            r_div_pend    <= w_div_pend_nxt;
            r_pending     <= w_pending_nxt;
            r_pos_hi      <= w_pos_hi_nxt;
            r_period_tick <= w_tick_nxt;
            r_cfg_err     <= w_cfg_err_nxt;
        end
    end

    // Half-cycle extension of the high phase, only for odd divisors.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_ext <= 1'b0;
        end else begin
            r_neg_ext <= r_pos_hi & r_div_cur[0];
        end
    end

    assign clk_out       = r_pos_hi | r_neg_ext;
    assign running       = (r_state == S_RUN);
    assign div_cur       = r_div_cur;
    assign period_tick   = r_period_tick;
    assign cfg.cfg_ready = ~r_pending;
    assign cfg.cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_clkdiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_clkdiv_ctrl                                               |
// | Description : Directed self-checking bench for clkdiv_ctrl.                |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_clkdiv_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clk_out;
    logic       running;
    logic [7:0] div_cur;
    logic       period_tick;

    int total;
    int bad;

    clkdiv_ctrl_if #(.W(8)) cfg_if ();

    clkdiv_ctrl #(.W(8), .DEFAULT_DIV(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .cfg         (cfg_if),
        .clk_out     (clk_out),
        .running     (running),
        .div_cur     (div_cur),
        .period_tick (period_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves the bench 1 time unit after a posedge with the DUT idle.
    task automatic do_reset();
        rst_n            = 1'b0;
        en               = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div   = 8'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        en               = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div   = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (clk_out !== 1'b0) begin bad++; $display("FAIL rst_clk_out got=%b exp=0", clk_out); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL rst_running got=%b exp=0", running); end
        total++; if (div_cur !== 8'd5) begin bad++; $display("FAIL rst_div_cur got=%0d exp=5", div_cur); end
        total++; if (cfg_if.cfg_ready !== 1'b1) begin bad++; $display("FAIL rst_cfg_ready got=%b exp=1", cfg_if.cfg_ready); end
        total++; if (cfg_if.cfg_err !== 1'b0) begin bad++; $display("FAIL rst_cfg_err got=%b exp=0", cfg_if.cfg_err); end
        total++; if (period_tick !== 1'b0) begin bad++; $display("FAIL rst_tick got=%b exp=0", period_tick); end
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (running !== 1'b0 || clk_out !== 1'b0) begin
            bad++; $display("FAIL rst_idle_hold got running=%b clk_out=%b exp 0/0", running, clk_out);
        end
    endtask

    // Test 1: default N=5, high 5 half-cycles of 10.
    task automatic test_default_div();
        int p;
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 15; c++) begin
            p = c % 5;
            @(posedge clk); #1;
            total++; if (clk_out !== ((2*p) < 5)) begin bad++; $display("FAIL n5_pos c=%0d got=%b exp=%b", c, clk_out, (2*p) < 5); end
            total++; if (period_tick !== (p == 0)) begin bad++; $display("FAIL n5_tick c=%0d got=%b exp=%b", c, period_tick, p == 0); end
            total++; if (running !== 1'b1) begin bad++; $display("FAIL n5_running c=%0d got=%b exp=1", c, running); end
            @(negedge clk); #1;
            total++; if (clk_out !== ((2*p+1) < 5)) begin bad++; $display("FAIL n5_neg c=%0d got=%b exp=%b", c, clk_out, (2*p+1) < 5); end
        end
    endtask

    // Test 2: divisor loaded directly while idle, then even N=4.
    task automatic test_idle_cfg();
        int p;
        do_reset();
        total++; if (cfg_if.cfg_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", cfg_if.cfg_ready); end
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = 8'd4;
        @(posedge clk); #1;
        cfg_if.cfg_valid = 1'b0;
        total++; if (div_cur !== 8'd4) begin bad++; $display("FAIL idle_div_cur got=%0d exp=4", div_cur); end
        total++; if (running !== 1'b0 || clk_out !== 1'b0) begin
            bad++; $display("FAIL idle_still got running=%b clk_out=%b exp 0/0", running, clk_out);
        end
        en = 1'b1;
        for (int c = 0; c < 12; c++) begin
            p = c % 4;
            @(posedge clk); #1;
            total++; if (clk_out !== ((2*p) < 4)) begin bad++; $display("FAIL n4_pos c=%0d got=%b exp=%b", c, clk_out, (2*p) < 4); end
            total++; if (period_tick !== (p == 0)) begin bad++; $display("FAIL n4_tick c=%0d got=%b exp=%b", c, period_tick, p == 0); end
            total++; if (running !== 1'b1) begin bad++; $display("FAIL n4_running c=%0d got=%b exp=1", c, running); end
            @(negedge clk); #1;
            total++; if (clk_out !== ((2*p+1) < 4)) begin bad++; $display("FAIL n4_neg c=%0d got=%b exp=%b", c, clk_out, (2*p+1) < 4); end
        end
    endtask

    // Test 3: change 4 -> 7 offered at cnt=1, takes effect at the next wrap.
    task automatic test_ratio_change();
        int p;
        int n;
        do_reset();
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = 8'd4;
        @(posedge clk); #1;
        cfg_if.cfg_valid = 1'b0;
        en = 1'b1;
        for (int c = 0; c < 25; c++) begin
            if (c < 4) begin p = c; n = 4; end
            else begin p = (c - 4) % 7; n = 7; end
            @(posedge clk); #1;
            total++; if (clk_out !== ((2*p) < n)) begin bad++; $display("FAIL chg_pos c=%0d got=%b exp=%b", c, clk_out, (2*p) < n); end
            total++; if (period_tick !== (p == 0)) begin bad++; $display("FAIL chg_tick c=%0d got=%b exp=%b", c, period_tick, p == 0); end
            total++; if (div_cur !== ((c < 4) ? 8'd4 : 8'd7)) begin bad++; $display("FAIL chg_div_cur c=%0d got=%0d exp=%0d", c, div_cur, (c < 4) ? 4 : 7); end
            total++; if (cfg_if.cfg_ready !== ((c == 2 || c == 3) ? 1'b0 : 1'b1)) begin
                bad++; $display("FAIL chg_ready c=%0d got=%b exp=%b", c, cfg_if.cfg_ready, !(c == 2 || c == 3));
            end
            if (c == 1) begin
                cfg_if.cfg_valid = 1'b1;
                cfg_if.cfg_div   = 8'd7;
            end else begin
                cfg_if.cfg_valid = 1'b0;
            end
            @(negedge clk); #1;
            total++; if (clk_out !== ((2*p+1) < n)) begin bad++; $display("FAIL chg_neg c=%0d got=%b exp=%b", c, clk_out, (2*p+1) < n); end
        end
    endtask

    // Test 4: en drops at cnt=2 of N=6; the period finishes, then idle.
    task automatic test_stop();
        do_reset();
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = 8'd6;
        @(posedge clk); #1;
        cfg_if.cfg_valid = 1'b0;
        en = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            total++; if (clk_out !== ((c < 6) && ((2*c) < 6))) begin bad++; $display("FAIL stop_pos c=%0d got=%b exp=%b", c, clk_out, (c < 6) && ((2*c) < 6)); end
            total++; if (period_tick !== (c == 0)) begin bad++; $display("FAIL stop_tick c=%0d got=%b exp=%b", c, period_tick, c == 0); end
            total++; if (running !== (c < 6)) begin bad++; $display("FAIL stop_running c=%0d got=%b exp=%b", c, running, c < 6); end
            if (c == 2) en = 1'b0;
            @(negedge clk); #1;
            total++; if (clk_out !== ((c < 6) && ((2*c+1) < 6))) begin bad++; $display("FAIL stop_neg c=%0d got=%b exp=%b", c, clk_out, (c < 6) && ((2*c+1) < 6)); end
        end
        total++; if (div_cur !== 8'd6) begin bad++; $display("FAIL stop_div_cur got=%0d exp=6", div_cur); end
    endtask

    // Test 5: divisors 1 then 0 are accepted, flagged, and discarded.
    task automatic test_bad_cfg();
        int p;
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 15; c++) begin
            p = c % 5;
            @(posedge clk); #1;
            total++; if (clk_out !== ((2*p) < 5)) begin bad++; $display("FAIL bad_pos c=%0d got=%b exp=%b", c, clk_out, (2*p) < 5); end
            total++; if (cfg_if.cfg_err !== (c == 2 || c == 3)) begin bad++; $display("FAIL bad_err c=%0d got=%b exp=%b", c, cfg_if.cfg_err, c == 2 || c == 3); end
            total++; if (cfg_if.cfg_ready !== 1'b1) begin bad++; $display("FAIL bad_ready c=%0d got=%b exp=1", c, cfg_if.cfg_ready); end
            total++; if (div_cur !== 8'd5) begin bad++; $display("FAIL bad_div_cur c=%0d got=%0d exp=5", c, div_cur); end
            if (c == 1) begin
                cfg_if.cfg_valid = 1'b1;
                cfg_if.cfg_div   = 8'd1;
            end else if (c == 2) begin
                cfg_if.cfg_div   = 8'd0;
            end else begin
                cfg_if.cfg_valid = 1'b0;
            end
            @(negedge clk); #1;
            total++; if (clk_out !== ((2*p+1) < 5)) begin bad++; $display("FAIL bad_neg c=%0d got=%b exp=%b", c, clk_out, (2*p+1) < 5); end
        end
    endtask

    // Test 6: async reset in the high phase with a pending divisor, then restart.
    task automatic test_reset_mid();
        int p;
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                cfg_if.cfg_valid = 1'b1;
                cfg_if.cfg_div   = 8'd9;
            end else begin
                cfg_if.cfg_valid = 1'b0;
                total++; if (cfg_if.cfg_ready !== 1'b0) begin bad++; $display("FAIL mid_pending got=%b exp=0", cfg_if.cfg_ready); end
                total++; if (clk_out !== 1'b1) begin bad++; $display("FAIL mid_high got=%b exp=1", clk_out); end
            end
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if (clk_out !== 1'b0) begin bad++; $display("FAIL mid_async_clk got=%b exp=0", clk_out); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL mid_running got=%b exp=0", running); end
        total++; if (div_cur !== 8'd5) begin bad++; $display("FAIL mid_div_cur got=%0d exp=5", div_cur); end
        total++; if (cfg_if.cfg_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", cfg_if.cfg_ready); end
        @(negedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            p = c % 5;
            @(posedge clk); #1;
            total++; if (clk_out !== ((2*p) < 5)) begin bad++; $display("FAIL rst_restart_pos c=%0d got=%b exp=%b", c, clk_out, (2*p) < 5); end
            total++; if (period_tick !== (p == 0)) begin bad++; $display("FAIL rst_restart_tick c=%0d got=%b exp=%b", c, period_tick, p == 0); end
            total++; if (div_cur !== 8'd5) begin bad++; $display("FAIL rst_restart_div c=%0d got=%0d exp=5", c, div_cur); end
            @(negedge clk); #1;
            total++; if (clk_out !== ((2*p+1) < 5)) begin bad++; $display("FAIL rst_restart_neg c=%0d got=%b exp=%b", c, clk_out, (2*p+1) < 5); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_default_div();
        test_idle_cfg();
        test_ratio_change();
        test_stop();
        test_bad_cfg();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
